// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 VGA timing constants and coordinate type.
// Also used by the display-window checker and the frame-buffer reader.
package vga_timing_pkg;

    localparam int unsigned COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

    // Horizontal timing, in pixel counts
    localparam int unsigned H_SYNC_DEF       = 96;
    localparam int unsigned H_DISP_START_DEF = 144;
    localparam int unsigned H_DISP_END_DEF   = 784;
    localparam int unsigned H_TOTAL_DEF      = 800;

    // Vertical timing, in lines
    localparam int unsigned V_SYNC_DEF       = 2;
    localparam int unsigned V_DISP_START_DEF = 35;
    localparam int unsigned V_DISP_END_DEF   = 515;
    localparam int unsigned V_TOTAL_DEF      = 525;

    // Half-open window test: lo <= c < hi
    function automatic logic in_window(input coord_t c, input coord_t lo, input coord_t hi);
        return (c >= lo) && (c < hi);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Enable-gated wrap counter for one raster axis. Exposes the registered
// count, its next-state value (for same-edge output decode), and a
// terminal-count strobe that the caller qualifies with its own enable.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned TOTAL = H_TOTAL_DEF
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   en_i,
    output coord_t count_o,
    output coord_t count_next_o,
    output logic   wrap_o
);

    localparam coord_t LAST = coord_t'(TOTAL - 1);

    coord_t count_q;
    coord_t count_d;

    // Terminal count: the next enabled edge returns the counter to zero
    assign wrap_o = (count_q == LAST);

    // Next-state: reset wins, then an enabled advance with wrap
    always_comb begin
        // NOTE: default assignment first so every path drives count_d; no latch is inferred.
        count_d = count_q;
        if (rst_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = wrap_o ? '0 : count_q + coord_t'(1);
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignment for state so all registers update together at the edge.
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o      = count_q;
    assign count_next_o = count_d;

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster generator. Two axis counters produce the raster
// position; sync, display-enable, active-area coordinates and line/frame
// strobes are decoded from the next-state counts and registered on the
// same edge, so every output lines up with horiz_c/vert_c.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_SYNC       = H_SYNC_DEF,
    parameter int unsigned H_DISP_START = H_DISP_START_DEF,
    parameter int unsigned H_DISP_END   = H_DISP_END_DEF,
    parameter int unsigned H_TOTAL      = H_TOTAL_DEF,
    parameter int unsigned V_SYNC       = V_SYNC_DEF,
    parameter int unsigned V_DISP_START = V_DISP_START_DEF,
    parameter int unsigned V_DISP_END   = V_DISP_END_DEF,
    parameter int unsigned V_TOTAL      = V_TOTAL_DEF,
    parameter logic        SYNC_ACTIVE  = 1'b0
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               PIX_EN,
    output logic [COORD_W-1:0] horiz_c,
    output logic [COORD_W-1:0] vert_c,
    output logic               HSYNC,
    output logic               VSYNC,
    output logic               DISP_EN,
    output logic [COORD_W-1:0] X,
    output logic [COORD_W-1:0] Y,
    output logic               LINE_START,
    output logic               FRAME_START
);

    localparam coord_t H_SYNC_C  = coord_t'(H_SYNC);
    localparam coord_t H_START_C = coord_t'(H_DISP_START);
    localparam coord_t H_END_C   = coord_t'(H_DISP_END);
    localparam coord_t V_SYNC_C  = coord_t'(V_SYNC);
    localparam coord_t V_START_C = coord_t'(V_DISP_START);
    localparam coord_t V_END_C   = coord_t'(V_DISP_END);

    coord_t h_q, h_d, v_q, v_d;
    logic   h_wrap, v_wrap, v_en;

    // Vertical axis steps only on an enabled horizontal wrap
    assign v_en = PIX_EN & h_wrap;

    vga_axis_counter #(.TOTAL(H_TOTAL)) u_horiz (
        .clk_i       (CLK),
        .rst_i       (RST),
        .en_i        (PIX_EN),
        .count_o     (h_q),
        .count_next_o(h_d),
        .wrap_o      (h_wrap)
    );

    vga_axis_counter #(.TOTAL(V_TOTAL)) u_vert (
        .clk_i       (CLK),
        .rst_i       (RST),
        .en_i        (v_en),
        .count_o     (v_q),
        .count_next_o(v_d),
        .wrap_o      (v_wrap)
    );

    logic   hsync_d, vsync_d, disp_d, line_start_d, frame_start_d;
    coord_t x_d, y_d;

    logic   hsync_q, vsync_q, disp_q, line_start_q, frame_start_q;
    coord_t x_q, y_q;

    // Decode level outputs from the position the counters are about to hold
    always_comb begin
        hsync_d       = (h_d < H_SYNC_C) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync_d       = (v_d < V_SYNC_C) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        disp_d        = in_window(h_d, H_START_C, H_END_C) && in_window(v_d, V_START_C, V_END_C);
        x_d           = disp_d ? (h_d - H_START_C) : '0;
        y_d           = disp_d ? (v_d - V_START_C) : '0;
        // Strobes only for a real advance across a wrap, never for a forced reset
        line_start_d  = ~RST & v_en;
        frame_start_d = ~RST & v_en & v_wrap;
    end

    // Output registers, loaded on the same edge as the counters
    always_ff @(posedge CLK) begin
        if (RST) begin
            hsync_q       <= SYNC_ACTIVE;
            vsync_q       <= SYNC_ACTIVE;
            disp_q        <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            disp_q        <= disp_d;
            x_q           <= x_d;
            y_q           <= y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign horiz_c     = h_q;
    assign vert_c      = v_q;
    assign HSYNC       = hsync_q;
    assign VSYNC       = vsync_q;
    assign DISP_EN     = disp_q;
    assign X           = x_q;
    assign Y           = y_q;
    assign LINE_START  = line_start_q;
    assign FRAME_START = frame_start_q;

endmodule
